rl_fifo_ctrl_1r1w: RTL and testbench
====================================

Name: rl_fifo_ctrl_1r1w

Overview:
Synchronous FIFO controller that sequences an external 1R1W RAM (DEPTH = 2**ABITS entries) as a circular buffer. It generates the write and read addresses and strobes, and tracks occupancy, full/empty/almost flags and error pulses. Pop data returns one cycle after an accepted pop, matching the RAM's registered read. Push is never accepted into a full FIFO, so the RAM never sees a same-address read/write in one cycle.

Parameters:
ABITS, 4, RAM address width; DEPTH = 2**ABITS
DBITS, 32, data width
AF_LVL, 2**ABITS-2, almost_full asserted when count >= AF_LVL
AE_LVL, 2, almost_empty asserted when count <= AE_LVL

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous clear
push  in  1  push request
push_data  in  DBITS  data to write
pop  in  1  pop request
pop_data  out  DBITS  popped data, valid when pop_valid=1
pop_valid  out  1  pop data valid, 1 cycle after accepted pop
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LVL
almost_empty  out  1  count <= AE_LVL
count  out  ABITS+1  occupancy 0..DEPTH
overflow  out  1  1-cycle pulse, push rejected because full
underflow  out  1  1-cycle pulse, pop rejected because empty
ram_waddr  out  ABITS  to RAM waddr
ram_din  out  DBITS  to RAM din, combinational = push_data
ram_we  out  1  to RAM we
ram_be  out  (DBITS+7)/8  all ones
ram_raddr  out  ABITS  to RAM raddr
ram_re  out  1  to RAM re
ram_dout  in  DBITS  from RAM dout, 1-cycle read latency

Behaviour:
- Interface decided: one clock, clk; reset is asynchronous, active-high, port rst.
- State: wptr and rptr, each ABITS+1 bits (the MSB is the wrap bit); count register ABITS+1 bits.
- Reset (async, effective immediately):
  - wptr=rptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0).
  - pop_valid=0, overflow=0, underflow=0.
- Accept conditions:
  - push_ok = push & ~full & ~clr.
  - pop_ok = pop & ~empty & ~clr.
  - Both use registered flags, so there is no bypass: pushing into an empty FIFO does not make the data poppable that cycle, and push while full is rejected even if pop is asserted.
- RAM drive (combinational):
  - ram_we=push_ok, ram_waddr=wptr[ABITS-1:0].
  - ram_re=pop_ok, ram_raddr=rptr[ABITS-1:0].
  - Because of the accept conditions, ram_we & ram_re never target the same address.
- Pointer update:
  - wptr += push_ok; rptr += pop_ok; both wrap modulo 2**(ABITS+1).
  - count += push_ok - pop_ok. Push_ok and pop_ok together leave count unchanged.
- Flags: registered, derived from the next count. full/empty equivalently satisfy wptr==rptr with wrap bits differing/equal.
- Pop data path:
  - pop_valid <= pop_ok.
  - pop_data = ram_dout (passthrough). It is only meaningful while pop_valid=1.
  - Back-to-back pops give one word per cycle.
- Error pulses:
  - overflow <= push & full & ~clr.
  - underflow <= pop & empty & ~clr.
  - Both are asserted the cycle after the request, for exactly 1 cycle each.
- clr:
  - Next edge: pointers/count/flags take reset values, overflow=underflow=0, pop_valid=0.
  - push/pop in the clr cycle are ignored and RAM strobes are 0.
  - A pop accepted the cycle before clr still delivers pop_valid=1 during the clr cycle.
- Reset mid-operation: in-flight pop_valid is dropped. RAM contents are irrelevant because pointers restart at 0.

Test Plan:
- Reset then idle (ABITS=4) -> empty=1, full=0, count=0, almost_empty=1, pop_valid=0, no ram_we/ram_re.
- Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 back-to-back -> ram_waddr 0,1,2; ram_raddr 0,1,2; pop_valid high 3 cycles, one cycle after each pop, with pop_data 0x11,0x22,0x33; count returns to 0, empty=1.
- Fill 16 entries -> full=1, count=16, almost_full asserted at count 14.
  - Then push+pop together -> push rejected, overflow pulse, pop accepted, count=15.
  - Then push+pop at count 15 -> both accepted, count stays 15, ram_waddr != ram_raddr.
- Wrap-around: 40 push/pop pairs at steady count 5 -> addresses wrap 15->0; data order preserved; full/empty never falsely asserted.
- Pop on empty, and simultaneous push+pop on empty -> underflow pulse 1 cycle, pop ignored (ram_re=0), push accepted, count=1, no pop_valid.
- clr at count 7 with pop accepted the prior cycle -> pop_valid=1 in the clr cycle, then count=0, empty=1.
  - Push asserted in the clr cycle is dropped (ram_we=0).
  - Async rst mid-burst clears pop_valid immediately.

Source files
------------

// File: rtl/rl_fifo_ctrl_1r1w.sv
// Circular-buffer controller for an external 1R1W RAM with registered read.
// Flags and error pulses are registered; accept decisions use only the registered flags.
module rl_fifo_ctrl_1r1w #(
  parameter int ABITS  = 4,
  parameter int DBITS  = 32,
  parameter int AF_LVL = 2**ABITS - 2,
  parameter int AE_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [DBITS-1:0]       push_data,
  input  logic                   pop,
  output logic [DBITS-1:0]       pop_data,
  output logic                   pop_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ABITS:0]         count,
  output logic                   overflow,
  output logic                   underflow,
  output logic [ABITS-1:0]       ram_waddr,
  output logic [DBITS-1:0]       ram_din,
  output logic                   ram_we,
  output logic [(DBITS+7)/8-1:0] ram_be,
  output logic [ABITS-1:0]       ram_raddr,
  output logic                   ram_re,
  input  logic [DBITS-1:0]       ram_dout
);

  localparam logic [ABITS:0] DEPTH_C = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] AF_C    = (ABITS+1)'(AF_LVL);
  localparam logic [ABITS:0] AE_C    = (ABITS+1)'(AE_LVL);
  localparam logic           AF_RST  = (AF_LVL == 0);
  localparam logic           AE_RST  = (AE_LVL >= 0);

  logic [ABITS:0] wptr_q, wptr_d;
  logic [ABITS:0] rptr_q, rptr_d;
  logic [ABITS:0] count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           af_q, af_d;
  logic           ae_q, ae_d;
  logic           pop_valid_q, pop_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           push_ok;
  logic           pop_ok;

  // No bypass: a push into an empty FIFO only becomes poppable next cycle.
  assign push_ok = push & ~full_q & ~clr;
  assign pop_ok  = pop & ~empty_q & ~clr;

  always_comb begin
    wptr_d      = wptr_q + {{ABITS{1'b0}}, push_ok};
    rptr_d      = rptr_q + {{ABITS{1'b0}}, pop_ok};
    count_d     = count_q + {{ABITS{1'b0}}, push_ok} - {{ABITS{1'b0}}, pop_ok};
    pop_valid_d = pop_ok;
    overflow_d  = push & full_q & ~clr;
    underflow_d = pop & empty_q & ~clr;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= AF_RST;
      ae_q        <= AE_RST;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_we       = push_ok;
  assign ram_waddr    = wptr_q[ABITS-1:0];
  assign ram_din      = push_data;
  assign ram_be       = '1;
  assign ram_re       = pop_ok;
  assign ram_raddr    = rptr_q[ABITS-1:0];

  assign pop_data     = ram_dout;
  assign pop_valid    = pop_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rl_fifo_ctrl_1r1w.sv
// Scoreboard bench for rl_fifo_ctrl_1r1w with a behavioural registered-read RAM.
module tb_rl_fifo_ctrl_1r1w;
  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst, clr, push, pop;
  logic [DBITS-1:0] push_data, pop_data, ram_din, ram_dout;
  logic             pop_valid, full, empty, almost_full, almost_empty;
  logic [ABITS:0]   count;
  logic             overflow, underflow, ram_we, ram_re;
  logic [ABITS-1:0] ram_waddr, ram_raddr;
  logic [3:0]       ram_be;

  logic [DBITS-1:0] mem [DEPTH];

  int               n_chk = 0;
  int               n_fail = 0;
  int               m_cnt;
  logic [ABITS:0]   m_wp, m_rp;
  logic [DBITS-1:0] exp_q [$];

  rl_fifo_ctrl_1r1w #(.ABITS(ABITS), .DBITS(DBITS), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_be(ram_be), .ram_raddr(ram_raddr), .ram_re(ram_re),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_wp  = '0;
    m_rp  = '0;
    exp_q.delete();
  endtask

  task automatic check_flags();
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("almost_full", almost_full, m_cnt >= 14);
    chk("almost_empty", almost_empty, m_cnt <= 2);
  endtask

  // One clock of stimulus: strobes checked before the edge, registered outputs after it.
  task automatic step(input logic p, input logic [DBITS-1:0] d, input logic q, input logic c);
    logic p_ok, q_ok, ovf, unf;
    logic [DBITS-1:0] pd;
    pd = '0;
    @(negedge clk);
    push = p; push_data = d; pop = q; clr = c;
    p_ok = p && (m_cnt != DEPTH) && !c;
    q_ok = q && (m_cnt != 0) && !c;
    ovf  = p && (m_cnt == DEPTH) && !c;
    unf  = q && (m_cnt == 0) && !c;
    #1;
    chk("ram_we", ram_we, p_ok);
    chk("ram_re", ram_re, q_ok);
    chk("ram_din", ram_din, d);
    chk("ram_be", ram_be, 4'hf);
    if (p_ok) chk("ram_waddr", ram_waddr, m_wp[ABITS-1:0]);
    if (q_ok) chk("ram_raddr", ram_raddr, m_rp[ABITS-1:0]);
    if (p_ok && q_ok) chk("addr_differ", ram_waddr != ram_raddr, 1);
    if (q_ok) begin
      pd = exp_q.pop_front();
      m_rp++;
    end
    if (p_ok) begin
      exp_q.push_back(d);
      m_wp++;
    end
    m_cnt = m_cnt + int'(p_ok) - int'(q_ok);
    if (c) model_reset();
    @(posedge clk);
    #1;
    chk("pop_valid", pop_valid, q_ok);
    if (q_ok) chk("pop_data", pop_data, pd);
    chk("overflow", overflow, ovf);
    chk("underflow", underflow, unf);
    check_flags();
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    push = 0; pop = 0; clr = 0; push_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr = 0; push = 0; pop = 0; push_data = '0;
    model_reset();
    #3;
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    check_flags();
    repeat (2) @(negedge clk);
    rst = 0;

    // Simple push 3 / pop 3
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill, then push+pop at full and at full-1
    for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0);
    step(1, 32'hdead_0001, 1, 0);
    step(1, 32'hdead_0002, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

    // Wrap-around at steady occupancy 5
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    for (int i = 0; i < 40; i++) step(1, $urandom, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

    // Pop on empty, then push+pop on empty
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 32'h5555_aaaa, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // clr at count 7 with a pop accepted the cycle before
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'hcafe_f00d, 1, 1);
    step(0, 0, 0, 0);
    step(1, 32'h0bad_beef, 0, 0);
    step(0, 0, 1, 0);

    // Async reset while a pop result is in flight
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_pop_valid", pop_valid, 1);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("async_rst_pop_valid", pop_valid, 0);
    check_flags();
    idle_inputs();
    rst = 0;
    step(1, 32'h1234_5678, 0, 0);
    step(0, 0, 1, 0);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
